// File: rtl/accel_pkg.sv
// accel_pkg: register map defaults, opcodes and driver state encoding for the math accelerator
package accel_pkg;
    localparam logic [3:0] ADDR_A_DEF      = 4'h0;
    localparam logic [3:0] ADDR_B_DEF      = 4'h1;
    localparam logic [3:0] ADDR_OP_DEF     = 4'h4;
    localparam logic [3:0] ADDR_RES_LO_DEF = 4'h5;
    localparam logic [3:0] ADDR_RES_HI_DEF = 4'h6;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;

    typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_OP, SETTLE, RD_LO, RD_HI, RESP} state_t;
endpackage

// File: rtl/accel_cmd_driver.sv
// accel_cmd_driver: writes operands to the math accelerator, reads back the result, returns it over valid/ready
module accel_cmd_driver
    import accel_pkg::*;
#(
    parameter logic [3:0]  ADDR_A        = ADDR_A_DEF,
    parameter logic [3:0]  ADDR_B        = ADDR_B_DEF,
    parameter logic [3:0]  ADDR_OP       = ADDR_OP_DEF,
    parameter logic [3:0]  ADDR_RES_LO   = ADDR_RES_LO_DEF,
    parameter logic [3:0]  ADDR_RES_HI   = ADDR_RES_HI_DEF,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    input  logic        sync_clear,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_divzero,
    output logic [3:0]  bus_address,
    output logic        bus_write,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata
);
    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d, b_q, b_d, sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [2:0]  op_q, op_d, sh_op_q, sh_op_d, need_q, need_d;
    logic        sh_valid_q, sh_valid_d, dirty_q, dirty_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_divzero_q, rsp_divzero_d;
    logic [15:0] rsp_result_q, rsp_result_d;
    logic [3:0]  bus_address_q, bus_address_d;
    logic        bus_write_q, bus_write_d;
    logic [7:0]  bus_wdata_q, bus_wdata_d;
    logic        accept, keep;

    // need = {op, b, a}: the earliest pending write, else settle or straight to readback
    function automatic state_t first_state(input logic [2:0] need);
        return need[0] ? WR_A : need[1] ? WR_B : need[2] ? WR_OP :
               (SETTLE_CYCLES != 0) ? SETTLE : RD_LO;
    endfunction

    assign cmd_ready   = (state_q == IDLE) && !rst;
    assign accept      = cmd_valid && cmd_ready;
    assign keep        = sh_valid_q && !sync_clear;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_divzero = rsp_divzero_q;
    assign bus_address = bus_address_q;
    assign bus_write   = bus_write_q;
    assign bus_wdata   = bus_wdata_q;

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        need_d        = need_q;
        sh_a_d        = sh_a_q;
        sh_b_d        = sh_b_q;
        sh_op_d       = sh_op_q;
        cnt_d         = cnt_q;
        rsp_result_d  = rsp_result_q;
        rsp_divzero_d = rsp_divzero_q;
        case (state_q)
            IDLE: if (accept) begin
                a_d           = cmd_a;
                b_d           = cmd_b;
                op_d          = cmd_op;
                need_d        = {!(keep && cmd_op == sh_op_q), !(keep && cmd_b == sh_b_q),
                                 !(keep && cmd_a == sh_a_q)};
                state_d       = first_state(need_d);
                rsp_divzero_d = (cmd_op == OP_DIV) && (cmd_b == 8'h00);
            end
            WR_A: begin
                sh_a_d  = a_q;
                state_d = first_state({need_q[2:1], 1'b0});
            end
            WR_B: begin
                sh_b_d  = b_q;
                state_d = first_state({need_q[2], 2'b00});
            end
            WR_OP: begin
                sh_op_d = op_q;
                state_d = first_state(3'b000);
            end
            SETTLE: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd0) ? RD_LO : SETTLE;
            end
            RD_LO: begin
                rsp_result_d[7:0] = bus_rdata;
                state_d           = RD_HI;
            end
            RD_HI: begin
                rsp_result_d[15:8] = bus_rdata;
                state_d            = RESP;
            end
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        if (state_d == SETTLE && state_q != SETTLE)
            cnt_d = 4'(SETTLE_CYCLES - 1);
        // a clear seen at any point after accept means the writes of this command can't be trusted
        dirty_d       = accept ? 1'b0 : (dirty_q || sync_clear);
        sh_valid_d    = sync_clear ? 1'b0 : (state_q == WR_OP) ? !dirty_q : sh_valid_q;
        rsp_valid_d   = state_d == RESP;
        bus_write_d   = state_d == WR_A || state_d == WR_B || state_d == WR_OP;
        bus_address_d = state_d == WR_A  ? ADDR_A :
                        state_d == WR_B  ? ADDR_B :
                        state_d == WR_OP ? ADDR_OP :
                        state_d == RD_LO ? ADDR_RES_LO :
                        state_d == RD_HI ? ADDR_RES_HI : 4'h0;
        bus_wdata_d   = state_d == WR_A  ? a_d :
                        state_d == WR_B  ? b_d :
                        state_d == WR_OP ? {5'b00000, op_d} : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            need_q        <= '0;
            sh_a_q        <= '0;
            sh_b_q        <= '0;
            sh_op_q       <= '0;
            sh_valid_q    <= 1'b0;
            dirty_q       <= 1'b0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_divzero_q <= 1'b0;
            bus_address_q <= '0;
            bus_write_q   <= 1'b0;
            bus_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            need_q        <= need_d;
            sh_a_q        <= sh_a_d;
            sh_b_q        <= sh_b_d;
            sh_op_q       <= sh_op_d;
            sh_valid_q    <= sh_valid_d;
            dirty_q       <= dirty_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_divzero_q <= rsp_divzero_d;
            bus_address_q <= bus_address_d;
            bus_write_q   <= bus_write_d;
            bus_wdata_q   <= bus_wdata_d;
        end
    end
endmodule
